// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a per-register busy scoreboard; REG_FILE_BYPASS_EN forwards same-edge writes to reads.
// Latency 1 cycle for reads, writes and scoreboard updates; no backpressure, every enabled request is taken each cycle.
module reg_file_mp #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_RD-1:0]                rd_en,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0]      wr_data,
  input  logic                             sb_set_en,
  input  logic [REG_ADDR_WIDTH-1:0]        sb_set_addr,
  output logic                             any_busy
);

  logic [REG_WIDTH-1:0]      regs     [NUM_REG];
  logic [REG_WIDTH-1:0]      regs_nxt [NUM_REG];
  logic [REG_WIDTH-1:0]      rd_src   [NUM_REG];
  logic [NUM_REG-1:0]        busy;
  logic [NUM_REG-1:0]        busy_clr;
  logic [NUM_REG-1:0]        busy_nxt;
  logic [NUM_REG-1:0]        busy_src;
  logic [REG_ADDR_WIDTH-1:0] wa;

  // Ports are applied in ascending order so the highest-index writer wins a collision;
  // busy_clr holds the post-write scoreboard before this cycle's set is merged in.
  always_comb begin
    regs_nxt = regs;
    busy_clr = busy;
    wa       = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa = wr_addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (wr_en[j] && (wa != '0)) begin
        regs_nxt[wa] = wr_data[j*REG_WIDTH +: REG_WIDTH];
        busy_clr[wa] = 1'b0;
      end
    end
    busy_nxt = busy_clr;
    if (sb_set_en && (sb_set_addr != '0)) begin
      busy_nxt[sb_set_addr] = 1'b1;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward the winning write and its busy clear, but never a same-cycle set.
  assign rd_src   = regs_nxt;
  assign busy_src = busy_clr;
`else
  assign rd_src   = regs;
  assign busy_src = busy;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
      any_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs[i] <= regs_nxt[i];
      end
      busy     <= busy_nxt;
      any_busy <= |busy_nxt;
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en[k]) begin
          rd_data[k*REG_WIDTH +: REG_WIDTH] <= rd_src[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
          rd_busy[k]                        <= busy_src[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp (2 read, 2 write ports): table vectors plus hand sequences, checked through an expectation queue.
module tb_reg_file_mp;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        any_busy;

  int errors = 0;
  int checks = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_file_mp #(
    .NUM_REG(32), .REG_ADDR_WIDTH(5), .REG_WIDTH(32), .NUM_RD(2), .NUM_WR(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .any_busy(any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        se;
    logic [4:0]  sa;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic        eany;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[15];

  function automatic vec_t v(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                             logic [4:0] wa1, logic [31:0] wd1, logic se, logic [4:0] sa,
                             logic [1:0] re, logic [4:0] ra0, logic [4:0] ra1,
                             logic [31:0] ed0, logic [31:0] ed1, logic eb0, logic eb1, logic eany);
    vec_t t;
    t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.se = se; t.sa = sa; t.re = re; t.ra0 = ra0; t.ra1 = ra1;
    t.ed0 = ed0; t.ed1 = ed1; t.eb0 = eb0; t.eb1 = eb1; t.eany = eany;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; rd_en = 2'b00; rd_addr = '0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, and compare after the edge.
  task automatic apply(input vec_t t, input string tag);
    vec_t e;
    wr_en = t.we; wr_addr = {t.wa1, t.wa0}; wr_data = {t.wd1, t.wd0};
    sb_set_en = t.se; sb_set_addr = t.sa;
    rd_en = t.re; rd_addr = {t.ra1, t.ra0};
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    idle();
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s queue: empty, expected 1 entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " rd_data0"}, rd_data[31:0], e.ed0);
      chk({tag, " rd_data1"}, rd_data[63:32], e.ed1);
      chk({tag, " rd_busy0"}, {31'd0, rd_busy[0]}, {31'd0, e.eb0});
      chk({tag, " rd_busy1"}, {31'd0, rd_busy[1]}, {31'd0, e.eb1});
      chk({tag, " any_busy"}, {31'd0, any_busy}, {31'd0, e.eany});
    end
  endtask

  logic [31:0] x10v;
  logic        x10b;
  logic [31:0] x11v;

  initial begin
    reset_n = 1'b0;
    idle();

    //        we    wa0 wd0           wa1 wd1    se sa  re    ra0 ra1 ed0           ed1    eb0 eb1 any
    tbl[0]  = v(2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0, 2'b00, 0, 0, 0,            0,     0, 0, 0);
    tbl[1]  = v(2'b01, 0, 32'h1234,     0, 0,     0, 0, 2'b11, 5, 0, 32'hDEADBEEF, 0,     0, 0, 0);
    tbl[2]  = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b01, 0, 0, 0,            0,     0, 0, 0);
    tbl[3]  = v(2'b11, 7, 32'h11,       7, 32'h22,0, 0, 2'b00, 0, 0, 0,            0,     0, 0, 0);
    tbl[4]  = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b10, 0, 7, 0,            32'h22,0, 0, 0);
    tbl[5]  = v(2'b00, 0, 0,            0, 0,     1, 3, 2'b00, 0, 0, 0,            32'h22,0, 0, 1);
    tbl[6]  = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b01, 3, 0, 0,            32'h22,1, 0, 1);
    tbl[7]  = v(2'b01, 3, 32'h55,       0, 0,     1, 3, 2'b00, 0, 0, 0,            32'h22,1, 0, 1);
    tbl[8]  = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b11, 3, 3, 32'h55,       32'h55,1, 1, 1);
    tbl[9]  = v(2'b10, 0, 0,            3, 32'h56,0, 0, 2'b00, 0, 0, 32'h55,       32'h55,1, 1, 0);
    tbl[10] = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b01, 3, 0, 32'h56,       32'h55,0, 1, 0);
    tbl[11] = v(2'b00, 0, 0,            0, 0,     1, 0, 2'b10, 0, 0, 32'h56,       0,     0, 0, 0);
    tbl[12] = v(2'b00, 0, 0,            0, 0,     1, 4, 2'b01, 4, 0, 0,            0,     0, 0, 1);
    tbl[13] = v(2'b00, 0, 0,            0, 0,     0, 0, 2'b01, 4, 0, 0,            0,     1, 0, 1);
    tbl[14] = v(2'b01, 4, 32'h77,       0, 0,     0, 0, 2'b00, 0, 0, 0,            0,     1, 0, 0);

    #12;
    chk("reset rd_data", rd_data[31:0] | rd_data[63:32], 32'd0);
    chk("reset busy", {29'd0, rd_busy, any_busy}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Same-edge write/read of x9 and rd_en hold.
    apply(v(2'b01, 9, 32'hA, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0), "byp_pre");
    apply(v(2'b01, 9, 32'hB, 0, 0, 0, 0, 2'b01, 9, 0, BYP ? 32'hB : 32'hA, 0, 0, 0, 0), "byp_rd");
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 32'hB, 0, 0, 0, 0), "hold_rd");
    apply(v(2'b01, 9, 32'hC, 0, 0, 0, 0, 2'b00, 0, 0, 32'hB, 0, 0, 0, 0), "hold_wr");
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'hB, 0, 0, 0, 0), "hold_keep");
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 32'hC, 0, 0, 0, 0), "hold_reen");

    // Same-edge busy clear and colliding writes as seen by a read.
    x10v = BYP ? 32'h10 : 32'h0;
    x10b = BYP ? 1'b0 : 1'b1;
    x11v = BYP ? 32'h2 : 32'h0;
    apply(v(2'b00, 0, 0, 0, 0, 1, 10, 2'b00, 0, 0, 32'hC, 0, 0, 0, 1), "sb10");
    apply(v(2'b01, 10, 32'h10, 0, 0, 0, 0, 2'b11, 10, 10, x10v, x10v, x10b, x10b, 0), "byp_busy");
    apply(v(2'b11, 11, 32'h1, 11, 32'h2, 0, 0, 2'b10, 0, 11, x10v, x11v, x10b, 0, 0), "byp_coll");
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 11, 0, 32'h2, x11v, 0, 0, 0), "coll_rd");

    // Asynchronous reset mid-stream.
    apply(v(2'b01, 5, 32'h99, 0, 0, 1, 6, 2'b00, 0, 0, 32'h2, x11v, 0, 0, 1), "rst_pre");
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5, 6, 32'h99, 0, 0, 1, 1), "rst_rd");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst rd_data0", rd_data[31:0], 32'd0);
    chk("async rst rd_data1", rd_data[63:32], 32'd0);
    chk("async rst busy", {29'd0, rd_busy, any_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(v(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5, 6, 0, 0, 0, 0, 0), "post_rst");

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL queue drain: got %0d entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
